spike_rate_decoder: RTL and testbench

Rate decoder at the receive end of the neuron spike interface. It samples a 1-bit spike train, counts spikes over a programmable window of clock cycles, and publishes one 8-bit rate word per window on a valid/ready output port. It sits after a neuron's `spike` output. Its rate word can drive the `current` input of a downstream neuron, or be read out for test.

---
 rtl/spike_rate_decoder.sv | 180 ++++++++++++++++++
 tb/tb_spike_rate_decoder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
//
// Receive-side rate decoder for a neuron spike train. Counts spikes over a
// programmable window of clock cycles and publishes one rate word per window
// on a valid/ready output port.
//
// Optional feature macro: SPIKE_DEC_EMA_EN
//   defined   -> rate carries an exponential moving average of the window
//                counts: ema_next = (3*ema + count) >> 2
//   undefined -> rate carries the raw saturated window count
//
// Parameters:
//   CNT_W        width of the spike counter and of rate (saturating)
//
// Ports:
//   clk          clock, rising edge
//   reset_n      synchronous active-low reset
//   enable       run decoding; low returns the FSM to IDLE
//   spike        spike input, sampled every clock while counting
//   window_len   window length in cycles, latched at window start (0 = 256)
//   rate         published rate word
//   rate_valid   rate holds an unconsumed result
//   rate_ready   consumer accepts rate when rate_valid && rate_ready
//   overrun      sticky: an unconsumed result was overwritten
//   busy         high while counting
// -----------------------------------------------------------------------------
module spike_rate_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             spike,
  input  logic [7:0]       window_len,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [7:0]       win_len;
  logic [7:0]       cyc_cnt;
  logic [CNT_W-1:0] spike_cnt;
  logic [CNT_W-1:0] cnt_sat;
  logic [CNT_W-1:0] result;

  logic             last_cycle;
  logic             start_window;
  logic             count_step;
  logic             window_done;

  // The 8-bit subtraction wraps a latched length of 0 to 255, which makes a
  // zero length behave as a 256-cycle window without any special case.
  assign last_cycle = (cyc_cnt == win_len - 8'd1);

  // Spike count including this cycle's sample, held at all-ones once full.
  assign cnt_sat = (spike && (spike_cnt != {CNT_W{1'b1}})) ?
                   spike_cnt + CNT_W'(1) : spike_cnt;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == COUNT);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and datapath controls
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    start_window = 1'b0;
    count_step   = 1'b0;
    window_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_next   = COUNT;
          start_window = 1'b1;
        end
      end
      COUNT: begin
        if (!enable) begin
          // Partial window is abandoned; counters are re-cleared on restart.
          state_next = IDLE;
        end else if (last_cycle) begin
          // Publish and begin the next window on the same edge (no gap).
          window_done  = 1'b1;
          start_window = 1'b1;
        end else begin
          count_step = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Window and spike counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      win_len   <= 8'd0;
      cyc_cnt   <= 8'd0;
      spike_cnt <= '0;
    end else if (start_window) begin
      win_len   <= window_len;
      cyc_cnt   <= 8'd0;
      spike_cnt <= '0;
    end else if (count_step) begin
      cyc_cnt   <= cyc_cnt + 8'd1;
      spike_cnt <= cnt_sat;
    end
  end

  // ---------------------------------------------------------------------------
  // Result selection: smoothed or raw
  // ---------------------------------------------------------------------------
`ifdef SPIKE_DEC_EMA_EN
  logic [CNT_W-1:0] ema;
  logic [CNT_W+1:0] ema_sum;

  // 3*ema + count needs two extra bits; the >>2 brings it back to CNT_W.
  assign ema_sum = ({2'b00, ema} << 1) + {2'b00, ema} + {2'b00, cnt_sat};
  assign result  = ema_sum[CNT_W+1:2];

  // The average tracks every window, consumed or not, and survives enable
  // dropping; only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ema <= '0;
    end else if (window_done) begin
      ema <= result;
    end
  end
`else
  assign result = cnt_sat;
`endif

  // ---------------------------------------------------------------------------
  // Output register and valid/ready handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rate       <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (window_done) begin
      rate       <= result;
      rate_valid <= 1'b1;
      // Overwriting a result nobody took this edge loses data.
      if (rate_valid && !rate_ready) begin
        overrun <= 1'b1;
      end
    end else if (rate_valid && rate_ready) begin
      rate_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_decoder
//
// Self-checking bench for spike_rate_decoder. A behavioural model built from
// integer window bookkeeping predicts rate / rate_valid / overrun / busy; a
// compare process checks the DUT against it every cycle. Directed scenarios
// add hand-computed literal expectations, followed by a randomized run.
// Honours SPIKE_DEC_EMA_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_spike_rate_decoder;

  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic             spike = 1'b0;
  logic [7:0]       window_len = 8'd0;
  logic [CNT_W-1:0] rate;
  logic             rate_valid;
  logic             rate_ready = 1'b0;
  logic             overrun;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;
  bit done        = 1'b0;

  spike_rate_decoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .spike      (spike),
    .window_len (window_len),
    .rate       (rate),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: tracks the current window as integers (length, position,
  // unbounded spike total) and clips only when a result is published.
  // ---------------------------------------------------------------------------
  bit counting  = 1'b0;
  int m_win     = 0;
  int m_pos     = 0;
  int m_cnt     = 0;
  int m_ema     = 0;
  int m_rate    = 0;
  bit m_valid   = 1'b0;
  bit m_overrun = 1'b0;
  bit m_busy    = 1'b0;

  always @(posedge clk) begin
    bit have_res;
    int res;
    int clipped;
    have_res = 1'b0;
    res      = 0;
    if (!reset_n) begin
      counting  = 1'b0;
      m_win     = 0;
      m_pos     = 0;
      m_cnt     = 0;
      m_ema     = 0;
      m_rate    = 0;
      m_valid   = 1'b0;
      m_overrun = 1'b0;
    end else begin
      if (!counting) begin
        if (enable) begin
          counting = 1'b1;
          m_win    = (window_len == 8'd0) ? 256 : int'(window_len);
          m_pos    = 0;
          m_cnt    = 0;
        end
      end else if (!enable) begin
        counting = 1'b0;
      end else begin
        m_cnt += int'(spike);
        m_pos++;
        if (m_pos == m_win) begin
          clipped = (m_cnt > MAXC) ? MAXC : m_cnt;
`ifdef SPIKE_DEC_EMA_EN
          m_ema = (3 * m_ema + clipped) / 4;
          res   = m_ema;
`else
          res   = clipped;
`endif
          have_res = 1'b1;
          m_win    = (window_len == 8'd0) ? 256 : int'(window_len);
          m_pos    = 0;
          m_cnt    = 0;
        end
      end
      if (have_res) begin
        if (m_valid && !rate_ready) m_overrun = 1'b1;
        m_rate  = res;
        m_valid = 1'b1;
      end else if (m_valid && rate_ready) begin
        m_valid = 1'b0;
      end
    end
    m_busy = counting;
  end

  // Compare DUT against model on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_rate_valid", 32'(rate_valid), 32'(m_valid));
      check("model_overrun",    32'(overrun),    32'(m_overrun));
      check("model_busy",       32'(busy),       32'(m_busy));
      if (m_valid) check("model_rate", 32'(rate), 32'(m_rate));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change just after a falling edge
  // ---------------------------------------------------------------------------
  // Present sp for the next rising edge and return after it.
  task automatic drive_cycle(input logic sp);
    spike = sp;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    spike   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Selects the literal expectation matching the configured build.
  function automatic logic [31:0] exp_lit(input int raw_v, input int ema_v);
`ifdef SPIKE_DEC_EMA_EN
    return 32'(ema_v);
`else
    return 32'(raw_v);
`endif
  endfunction

  // Watchdog: a stuck run still reports and stops.
  initial begin
    #2_000_000;
    if (!done) begin
      $display("FAIL watchdog: run exceeded time limit");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "timeout");
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [9:0] pat1;
    @(negedge clk);
    @(negedge clk);
    // Reset state (reset held across two edges).
    check("reset_rate",       32'(rate),       32'd0);
    check("reset_rate_valid", 32'(rate_valid), 32'd0);
    check("reset_overrun",    32'(overrun),    32'd0);
    check("reset_busy",       32'(busy),       32'd0);
    cmp_en = 1'b1;
    reset_n = 1'b1;

    // --- Window of 10, 4 spikes, consumer always ready ----------------------
    pat1       = 10'b10_0010_1001;
    window_len = 8'd10;
    rate_ready = 1'b1;
    enable     = 1'b1;
    drive_cycle(1'b0);                       // IDLE -> COUNT edge
    check("win10_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) check("win10_not_early", 32'(rate_valid), 32'd0);
      drive_cycle(pat1[i]);
    end
    check("win10_valid", 32'(rate_valid), 32'd1);
    check("win10_rate",  32'(rate),       exp_lit(4, 1));
    drive_cycle(1'b0);
    check("win10_one_cycle", 32'(rate_valid), 32'd0);
    for (int i = 0; i < 9; i++) drive_cycle(1'b0);
    check("win10_no_gap_valid", 32'(rate_valid), 32'd1);
    check("win10_no_gap_rate",  32'(rate),       32'd0);
    enable = 1'b0;
    drive_cycle(1'b0);

    // --- Saturation with a zero (256-cycle) window ---------------------------
    do_reset();
    window_len = 8'd0;
    enable     = 1'b1;
    drive_cycle(1'b1);
    for (int i = 0; i < 256; i++) begin
      if (i == 255) check("sat_not_early", 32'(rate_valid), 32'd0);
      drive_cycle(1'b1);
    end
    check("sat_valid", 32'(rate_valid), 32'd1);
    check("sat_rate",  32'(rate),       exp_lit(255, 63));
    enable = 1'b0;
    drive_cycle(1'b0);

    // --- Transfer on the same edge a new result loads ------------------------
    do_reset();
    window_len = 8'd4;
    rate_ready = 1'b0;
    enable     = 1'b1;
    drive_cycle(1'b0);
    drive_cycle(1'b1); drive_cycle(1'b0); drive_cycle(1'b0); drive_cycle(1'b0);
    check("same_edge_first_rate", 32'(rate), exp_lit(1, 0));
    drive_cycle(1'b1); drive_cycle(1'b1); drive_cycle(1'b1);
    rate_ready = 1'b1;
    drive_cycle(1'b1);
    check("same_edge_rate",    32'(rate),       exp_lit(4, 1));
    check("same_edge_valid",   32'(rate_valid), 32'd1);
    check("same_edge_overrun", 32'(overrun),    32'd0);
    enable = 1'b0;
    drive_cycle(1'b0);

    // --- Abort at cycle 3 of an 8-cycle window -------------------------------
    do_reset();
    window_len = 8'd8;
    rate_ready = 1'b1;
    enable     = 1'b1;
    drive_cycle(1'b0);
    drive_cycle(1'b1); drive_cycle(1'b1); drive_cycle(1'b0);
    enable = 1'b0;
    drive_cycle(1'b1);
    check("abort_busy_low", 32'(busy), 32'd0);
    enable = 1'b1;
    drive_cycle(1'b0);
    check("abort_busy_back", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("abort_no_result", 32'(rate_valid), 32'd0);
      drive_cycle(i < 4);
    end
    check("abort_valid", 32'(rate_valid), 32'd1);
    check("abort_rate",  32'(rate),       exp_lit(4, 1));
    enable = 1'b0;
    drive_cycle(1'b0);

    // --- Overrun: two results with nobody consuming --------------------------
    do_reset();
    window_len = 8'd5;
    rate_ready = 1'b0;
    enable     = 1'b1;
    drive_cycle(1'b0);
    drive_cycle(1'b1); drive_cycle(1'b1); drive_cycle(1'b0);
    drive_cycle(1'b0); drive_cycle(1'b0);
    check("ovr_first_rate",    32'(rate),    32'd2 >> exp_lit(0, 2));
    check("ovr_first_overrun", 32'(overrun), 32'd0);
    drive_cycle(1'b1); drive_cycle(1'b0); drive_cycle(1'b1);
    drive_cycle(1'b1); drive_cycle(1'b0);
    check("ovr_second_rate",    32'(rate),       exp_lit(3, 0));
    check("ovr_second_valid",   32'(rate_valid), 32'd1);
    check("ovr_second_overrun", 32'(overrun),    32'd1);
    rate_ready = 1'b1;
    enable     = 1'b0;
    drive_cycle(1'b0);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // --- Smoothing sequence: counts 40, 40, 0 --------------------------------
    do_reset();
    window_len = 8'd40;
    rate_ready = 1'b1;
    enable     = 1'b1;
    drive_cycle(1'b0);
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 40; i++) drive_cycle(w < 2);
      case (w)
        0: check("ema_w0", 32'(rate), exp_lit(40, 10));
        1: check("ema_w1", 32'(rate), exp_lit(40, 17));
        default: check("ema_w2", 32'(rate), exp_lit(0, 12));
      endcase
    end
    enable = 1'b0;
    drive_cycle(1'b0);

    // --- Randomized run against the model ------------------------------------
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(7) == 0) begin
        window_len = ($urandom_range(30) == 0) ? 8'd0 : 8'($urandom_range(12, 1));
      end
      enable     = ($urandom_range(39) != 0);
      rate_ready = ($urandom_range(3) != 0);
      reset_n    = ($urandom_range(799) != 0);
      drive_cycle(1'($urandom_range(2) != 0));
    end
    reset_n = 1'b1;
    enable  = 1'b0;
    drive_cycle(1'b0);

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
